mem_arbiter: RTL and testbench

Byte-serial memory controller between the core's two memory clients (instruction cache refill, load/store buffer) and the 8-bit RAM/IO bus.
- Arbitrates between the two clients.
- Splits each 1/2/4-byte access into byte beats on mem_a/mem_dout/mem_din.
- Reassembles read data little-endian and returns it to the requester with a one-cycle valid pulse.
- Sits directly downstream of the fetch and load/store stages and drives the cpu top-level memory pins.

---
 rtl/mem_arbiter_pkg.sv | 12 +
 rtl/mem_byte_seq.sv | 33 +++
 rtl/mem_arbiter.sv | 106 ++++++++++
 tb/tb_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: FSM states, access size codes, IO marker, data-range macro and beat-count helper
`define MEM_DATA_R 31:0
package mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] IO_HI = 2'b11;
  function automatic logic [2:0] beats(input logic [1:0] size);
    return size == SZ_BYTE ? 3'd1 : size == SZ_HALF ? 3'd2 : size == SZ_WORD ? 3'd4 : 3'd4;
  endfunction
endpackage

// File: rtl/mem_byte_seq.sv
// mem_byte_seq: beat counter and byte address generator for one access
module mem_byte_seq #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              start,
  input  logic              run,
  input  logic              stall,
  input  logic [ADDR_W-1:0] base,
  input  logic [2:0]        n,
  output logic [2:0]        idx,
  output logic [ADDR_W-1:0] addr,
  output logic              last,
  output logic              fin
);
  logic [ADDR_W-1:0] base_q;
  logic [2:0] n_q;
  always_ff @(posedge clk)
    if (!rst) begin
      base_q <= '0;
      n_q <= '0;
      idx <= '0;
    end else if (rdy) begin
      base_q <= start ? base : base_q;
      n_q <= start ? n : n_q;
      idx <= start ? 3'd0 : run && !stall ? idx + 3'd1 : idx;
    end
  assign addr = base_q + ADDR_W'(idx);
  assign last = idx == n_q - 3'd1;
  assign fin = idx == n_q;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: byte-serial icache/LSB memory arbiter; IO write stall on io_buffer_full when MEM_ARB_IO_STALL_EN is defined
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               fet_ena,
  input  logic [ADDR_W-1:0]  instr_addr,
  output logic               valid_2icache,
  output logic [`MEM_DATA_R] data_2icache,
  input  logic               lsb_ena,
  input  logic               lsb_wr,
  input  logic [1:0]         lsb_size,
  input  logic [ADDR_W-1:0]  lsb_addr,
  input  logic [`MEM_DATA_R] lsb_wdata,
  output logic               valid_2lsb,
  output logic [`MEM_DATA_R] data_2lsb,
  input  logic               rollback_signal,
  input  logic [7:0]         mem_din,
  output logic [7:0]         mem_dout,
  output logic [ADDR_W-1:0]  mem_a,
  output logic               mem_wr,
  input  logic               io_buffer_full
);
  state_t state;
  logic src, take, stall, last, fin;
  logic [`MEM_DATA_R] wdata, asm_q, asm_nx;
  logic [2:0] idx;
  logic [ADDR_W-1:0] addr;
  assign take = state == IDLE && !rollback_signal && (lsb_ena || fet_ena);
  assign asm_nx = asm_q | (32'(mem_din) << {idx - 3'd1, 3'b000});
  mem_byte_seq #(.ADDR_W(ADDR_W)) u_seq (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .start(take),
    .run(state == READ || state == WRITE),
    .stall(stall),
    .base(lsb_ena ? lsb_addr : instr_addr),
    .n(lsb_ena ? beats(lsb_size) : 3'd4),
    .idx(idx),
    .addr(addr),
    .last(last),
    .fin(fin)
  );
`ifdef MEM_ARB_IO_STALL_EN
  logic io_q, io_w;
  always_ff @(posedge clk)
    if (!rst) begin
      io_q <= 1'b0;
      io_w <= 1'b0;
    end else if (rdy) begin
      io_q <= io_buffer_full;
      io_w <= take ? lsb_addr[17:16] == IO_HI : io_w;
    end
  assign stall = state == WRITE && io_w && io_q;
`else
  logic unused_io;
  assign unused_io = io_buffer_full;
  assign stall = 1'b0;
`endif
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      src <= 1'b0;
      wdata <= '0;
      asm_q <= '0;
      valid_2icache <= 1'b0;
      valid_2lsb <= 1'b0;
      data_2icache <= '0;
      data_2lsb <= '0;
    end else if (rdy) begin
      valid_2icache <= 1'b0;
      valid_2lsb <= 1'b0;
      case (state)
        IDLE: if (take) begin
          src <= lsb_ena;
          wdata <= lsb_wdata;
          asm_q <= '0;
          state <= lsb_ena && lsb_wr ? WRITE : READ;
        end
        READ: if (rollback_signal) state <= IDLE;
        else if (idx != 3'd0) begin
          asm_q <= asm_nx;
          if (fin) begin
            state <= DONE;
            valid_2lsb <= src;
            valid_2icache <= !src;
            data_2lsb <= src ? asm_nx : data_2lsb;
            data_2icache <= src ? data_2icache : asm_nx;
          end
        end
        WRITE: if (last && !stall) begin
          state <= DONE;
          valid_2lsb <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  assign mem_a = (state == READ && !fin) || state == WRITE ? addr : '0;
  assign mem_wr = rdy && state == WRITE && !stall;
  assign mem_dout = state == WRITE ? wdata[{idx[1:0], 3'b000} +: 8] : 8'h00;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
`ifdef MEM_ARB_IO_STALL_EN
  localparam int IO_S = 3;
`else
  localparam int IO_S = 0;
`endif
  logic clk = 1'b0;
  logic rst, rdy, fet_ena, lsb_ena, lsb_wr, rollback_signal, io_buffer_full;
  logic valid_2icache, valid_2lsb, mem_wr;
  logic [31:0] instr_addr, lsb_addr, lsb_wdata, data_2icache, data_2lsb, mem_a;
  logic [1:0] lsb_size;
  logic [7:0] mem_din, mem_dout;
  logic [7:0] ram [65536];
  logic [31:0] wlog [$];
  int wcyc [$];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int n, base;
  logic seen;
  logic [31:0] wd;
  mem_arbiter dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .fet_ena(fet_ena),
    .instr_addr(instr_addr),
    .valid_2icache(valid_2icache),
    .data_2icache(data_2icache),
    .lsb_ena(lsb_ena),
    .lsb_wr(lsb_wr),
    .lsb_size(lsb_size),
    .lsb_addr(lsb_addr),
    .lsb_wdata(lsb_wdata),
    .valid_2lsb(valid_2lsb),
    .data_2lsb(data_2lsb),
    .rollback_signal(rollback_signal),
    .mem_din(mem_din),
    .mem_dout(mem_dout),
    .mem_a(mem_a),
    .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rdy) mem_din <= ram[mem_a[15:0]];
    if (mem_wr) begin
      wlog.push_back({mem_a[15:0], 8'h00, mem_dout});
      wcyc.push_back(cyc);
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic wait_pulse(input bit lsb, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!(lsb ? valid_2lsb : valid_2icache) && cnt < 40);
  endtask
  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h1000] = 8'h13;
    ram[16'h1001] = 8'h05;
    ram[16'h2000] = 8'hAB;
    ram[16'h0400] = 8'h11;
    ram[16'h0401] = 8'h22;
    ram[16'h0402] = 8'h33;
    ram[16'h0403] = 8'h44;
    rst = 0;
    rdy = 1;
    fet_ena = 0;
    lsb_ena = 0;
    lsb_wr = 0;
    lsb_size = 0;
    instr_addr = 0;
    lsb_addr = 0;
    lsb_wdata = 0;
    rollback_signal = 0;
    io_buffer_full = 0;
    repeat (3) @(negedge clk);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_dout", mem_dout, 0);
    chk("rst_valids", {valid_2icache, valid_2lsb}, 0);
    chk("rst_data_ic", data_2icache, 0);
    chk("rst_data_lsb", data_2lsb, 0);
    rst = 1;
    @(negedge clk);
    fet_ena = 1;
    instr_addr = 32'h1000;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c <= 4) chk("if_mem_a", mem_a, 32'h1000 + c - 1);
      if (c == 5) chk("if_early", valid_2icache, 0);
    end
    chk("if_valid", valid_2icache, 1);
    chk("if_data", data_2icache, 32'h0000_0513);
    chk("if_lsb_quiet", valid_2lsb, 0);
    fet_ena = 0;
    @(negedge clk);
    chk("if_pulse_len", valid_2icache, 0);
    chk("if_idle_a", mem_a, 0);
    fet_ena = 1;
    lsb_ena = 1;
    lsb_wr = 0;
    lsb_size = 2'b00;
    lsb_addr = 32'h2000;
    wait_pulse(1, n);
    chk("prio_lat", n, 3);
    chk("prio_data", data_2lsb, 32'h0000_00AB);
    chk("prio_ic_quiet", valid_2icache, 0);
    lsb_ena = 0;
    wait_pulse(0, n);
    chk("prio_if_lat", n, 7);
    chk("prio_if_data", data_2icache, 32'h0000_0513);
    fet_ena = 0;
    @(negedge clk);
    base = wlog.size();
    wd = 32'hDEADBEEF;
    lsb_ena = 1;
    lsb_wr = 1;
    lsb_size = 2'b10;
    lsb_addr = 32'h100;
    lsb_wdata = wd;
    wait_pulse(1, n);
    chk("st_lat", n, 5);
    lsb_ena = 0;
    chk("st_beats", wlog.size() - base, 4);
    for (int k = 0; k < 4; k++) chk("st_beat", wlog[base + k], {16'h0100 + 16'(k), 8'h00, wd[8 * k +: 8]});
    chk("st_consec", wcyc[base + 3] - wcyc[base], 3);
    @(negedge clk);
    fet_ena = 1;
    instr_addr = 32'h1000;
    @(negedge clk);
    @(negedge clk);
    chk("rb_beat2_a", mem_a, 32'h1001);
    rollback_signal = 1;
    fet_ena = 0;
    @(negedge clk);
    chk("rb_idle", mem_a, 0);
    rollback_signal = 0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      seen |= valid_2icache;
    end
    chk("rb_no_valid", seen, 0);
    fet_ena = 1;
    rollback_signal = 1;
    @(negedge clk);
    chk("rb_block", mem_a, 0);
    fet_ena = 0;
    rollback_signal = 0;
    @(negedge clk);
    base = wlog.size();
    lsb_ena = 1;
    lsb_wr = 1;
    lsb_size = 2'b01;
    lsb_addr = 32'h200;
    lsb_wdata = 32'h0000_1234;
    @(negedge clk);
    rollback_signal = 1;
    wait_pulse(1, n);
    chk("rbst_lat", n, 2);
    rollback_signal = 0;
    lsb_ena = 0;
    chk("rbst_beats", wlog.size() - base, 2);
    chk("rbst_beat0", wlog[base], 32'h0200_0034);
    chk("rbst_beat1", wlog[base + 1], 32'h0201_0012);
    @(negedge clk);
    lsb_ena = 1;
    lsb_wr = 0;
    lsb_size = 2'b10;
    lsb_addr = 32'h400;
    @(negedge clk);
    @(negedge clk);
    rdy = 0;
    @(negedge clk);
    chk("rdy_hold_a", mem_a, 32'h401);
    @(negedge clk);
    rdy = 1;
    wait_pulse(1, n);
    chk("rdy_lat", n, 4);
    chk("rdy_data", data_2lsb, 32'h4433_2211);
    lsb_ena = 0;
    @(negedge clk);
    lsb_ena = 1;
    lsb_wr = 1;
    lsb_size = 2'b10;
    lsb_addr = 32'h500;
    lsb_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("wr_beat0", mem_wr, 1);
    chk("wr_dout0", mem_dout, 8'h0D);
    rdy = 0;
    #1;
    chk("rdy_wr_gate", mem_wr, 0);
    @(negedge clk);
    chk("rdy_wr_hold_a", mem_a, 32'h500);
    rdy = 1;
    @(negedge clk);
    chk("wr_beat1_a", mem_a, 32'h501);
    rst = 0;
    @(negedge clk);
    chk("rstw_mem_a", mem_a, 0);
    chk("rstw_mem_wr", mem_wr, 0);
    chk("rstw_dout", mem_dout, 0);
    chk("rstw_valids", {valid_2icache, valid_2lsb}, 0);
    chk("rstw_data_lsb", data_2lsb, 0);
    rst = 1;
    lsb_ena = 0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      seen |= valid_2lsb;
    end
    chk("rstw_no_valid", seen, 0);
    lsb_ena = 1;
    lsb_wr = 1;
    lsb_size = 2'b00;
    lsb_addr = 32'h30000;
    lsb_wdata = 32'h41;
    io_buffer_full = 1;
    for (int c = 1; c <= IO_S + 2; c++) begin
      @(negedge clk);
      if (c == 3) io_buffer_full = 0;
      if (c <= IO_S + 1) chk("io_wr", mem_wr, c == IO_S + 1);
      if (c == IO_S + 1) chk("io_beat", {mem_a[23:0], mem_dout}, 32'h0300_0041);
      if (c == IO_S + 2) chk("io_valid", valid_2lsb, 1);
    end
    io_buffer_full = 0;
    lsb_ena = 0;
    @(negedge clk);
    chk("io_done_idle", mem_a, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
